// File: rtl/seq_det_pkg.sv
// Shared types and constants for the round-robin serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } state_e;

    localparam logic FOUND    = 1'b1;
    localparam logic NOTFOUND = 1'b0;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1100;

endpackage

// File: rtl/seq_window_det.sv
// Mealy 4-bit window detector: three bits of history plus the current serial
// bit. The history is cleared per word so a hit never spans two words.
module seq_window_det
    import seq_det_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
    parameter int         IDX_W   = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [IDX_W-1:0] bit_idx,
    output logic             found
);

    logic [2:0] hist_q;
    logic [2:0] hist_d;

    // History advances one bit per shift; a new grant wipes it.
    always_comb begin
        hist_d = hist_q;
        if (clr) begin
            hist_d = '0;
        end else if (shift_en) begin
            hist_d = {hist_q[1:0], bit_in};
        end
    end

    // History register; always cleared before use, so it needs no reset.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    // The current bit completes the window; the first three bits cannot hit.
    always_comb begin
        found = NOTFOUND;
        if (shift_en && (bit_idx >= IDX_W'(3)) && ({hist_q, bit_in} == PATTERN)) begin
            found = FOUND;
        end
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin scheduler sharing one serial pattern detector among N_REQ
// requesters. The granted word is shifted MSB-first into the detector, hits
// are counted into a saturating counter and reported with the winner's ID.
// Optional build macro SEQ_DET_EARLY_ABORT_EN: the first hit ends the word.
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter int         N_REQ   = 4,
    parameter int         WORD_W  = 8,
    parameter int         CNT_W   = 4,
    parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
    localparam int        ID_W    = $clog2(N_REQ),
    localparam int        IDX_W   = $clog2(WORD_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    bit_out,
    output logic                    found,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        match_cnt
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               any_req;
    logic [ID_W-1:0]    winner;
    logic               win_clr;
    logic               found_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign bit_out   = (state_q == SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
    assign found     = found_w;
    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == REPORT);
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

    seq_window_det #(
        .PATTERN (PATTERN),
        .IDX_W   (IDX_W)
    ) u_win (
        .clk      (clk),
        .clr      (win_clr),
        .shift_en (state_q == SHIFT),
        .bit_in   (bit_out),
        .bit_idx  (bit_idx_q),
        .found    (found_w)
    );

    // Cyclic search for the first request at or after the round-robin pointer.
    always_comb begin
        int cand;
        any_req = 1'b0;
        winner  = '0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!any_req && req[ID_W'(cand)]) begin
                any_req = 1'b1;
                winner  = ID_W'(cand);
            end
        end
    end

    // Next-state logic: grant and load in IDLE, serialize in SHIFT, pulse in REPORT.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sreg_d      = sreg_q;
        bit_idx_d   = bit_idx_q;
        match_cnt_d = match_cnt_q;
        done_id_d   = done_id_q;
        gnt_d       = '0;
        win_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = SHIFT;
                    sreg_d      = WORD_W'(data >> (int'(winner) * WORD_W));
                    done_id_d   = winner;
                    match_cnt_d = '0;
                    bit_idx_d   = '0;
                    win_clr     = 1'b1;
                    gnt_d       = N_REQ'(1) << winner;
                    rr_ptr_d    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
                end
            end
            SHIFT: begin
                sreg_d    = sreg_q << 1;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (found_w == FOUND) begin
                    match_cnt_d = sat_inc(match_cnt_q);
                end
`ifdef SEQ_DET_EARLY_ABORT_EN
                if ((found_w == FOUND) || (bit_idx_q == IDX_W'(WORD_W - 1))) begin
                    state_d = REPORT;
                end
`else
                if (bit_idx_q == IDX_W'(WORD_W - 1)) begin
                    state_d = REPORT;
                end
`endif
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible result registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            bit_idx_q   <= '0;
            match_cnt_q <= '0;
            done_id_q   <= '0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            bit_idx_q   <= bit_idx_d;
            match_cnt_q <= match_cnt_d;
            done_id_q   <= done_id_d;
            gnt_q       <= gnt_d;
        end
    end

    // Shift register holds data only; it is reloaded on every grant.
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: a hand-written vector table, reset/contention
// sequences and randomized traffic checked against a transaction-level model.
module tb_seq_det_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [3:0] PAT = 4'b1100;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt, gnt1;
    logic           busy, busy1, bit_out, bit_out1, found, found1, done, done1;
    logic [1:0]     done_id, done_id1;
    logic [CW-1:0]  match_cnt;
    logic [0:0]     match_cnt1;

    seq_det_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
        .bit_out(bit_out), .found(found), .done(done), .done_id(done_id), .match_cnt(match_cnt)
    );

    seq_det_arbiter #(.CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt1), .busy(busy1),
        .bit_out(bit_out1), .found(found1), .done(done1), .done_id(done_id1), .match_cnt(match_cnt1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model state
    int           rr, last_id, last_cnt, last_cnt1;
    logic [N-1:0] pend;
    logic [W-1:0] words [N];

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] word;
        logic [N-1:0] gnt;
        int           id;
        int           cnt;
        int           cnt1;
        logic [W-1:0] fmask;
        logic [W-1:0] fmask_ab;
        int           cnt_ab;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pack();
        logic [N*W-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) d[i*W +: W] = words[i];
        return d;
    endfunction

    // Bit i of the mask is set when the i-th received bit completes PAT.
    function automatic logic [W-1:0] hit_mask(input logic [W-1:0] w);
        logic [W-1:0] m;
        m = '0;
        for (int i = 3; i < W; i++) if (w[W-1-i +: 4] == PAT) m[i] = 1'b1;
        return m;
    endfunction

    task automatic add_random();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i]  = 1'b1;
                words[i] = W'($urandom());
            end
        end
    endtask

    task automatic model_reset();
        rr = 0; last_id = 0; last_cnt = 0; last_cnt1 = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);         chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bit"}, bit_out, 0);     chk({tag, "_found"}, found, 0);
        chk({tag, "_done"}, done, 0);       chk({tag, "_id"}, done_id, 0);
        chk({tag, "_cnt"}, match_cnt, 0);   chk({tag, "_cnt1"}, match_cnt1, 0);
        chk({tag, "_done1"}, done1, 0);     chk({tag, "_busy1"}, busy1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; pend = '0;
        tick(); tick();
        chk_zero("rst");
        reset = 1'b0;
        model_reset();
    endtask

    // Run one arbitration slot starting in an IDLE cycle.
    task automatic serve(input bit drop, input bit rnd,
                         output logic [N-1:0] o_gnt, output int o_id,
                         output int o_cnt, output int o_cnt1, output logic [W-1:0] o_found);
        int           win, len, hits, exp_cnt, exp1;
        logic [W-1:0] w, m;
        logic [N-1:0] oh, sh;
        o_gnt = '0; o_id = 0; o_cnt = 0; o_cnt1 = 0; o_found = '0;
        req = pend; data = pack();
        chk("idle_busy", busy, 0);       chk("idle_done", done, 0);
        chk("idle_gnt", gnt, 0);         chk("idle_bit", bit_out, 0);
        chk("idle_found", found, 0);     chk("idle_id", done_id, last_id);
        chk("idle_cnt", match_cnt, last_cnt);
        chk("idle_cnt1", match_cnt1, last_cnt1);
        if (pend == '0) begin
            tick();
            return;
        end
        win = -1;
        for (int k = 0; k < N; k++) begin
            sh = pend >> ((rr + k) % N);
            if (win < 0 && sh[0]) win = (rr + k) % N;
        end
        w = words[win];
        m = hit_mask(w);
        len = W;
`ifdef SEQ_DET_EARLY_ABORT_EN
        m = m & (~m + 1'b1);
        for (int i = W - 1; i >= 0; i--) if (m[i]) len = i + 1;
`endif
        hits    = $countones(m);
        exp_cnt = (hits > MAXC) ? MAXC : hits;
        exp1    = (hits > 0) ? 1 : 0;
        oh      = N'(1) << win;
        rr      = (win + 1) % N;
        if (drop) pend = pend & ~oh;
        for (int k = 1; k <= len; k++) begin
            tick();
            chk("sh_gnt", gnt, (k == 1) ? oh : '0);
            chk("sh_gnt1", gnt1, (k == 1) ? oh : '0);
            chk("sh_busy", busy, 1);     chk("sh_busy1", busy1, 1);
            chk("sh_done", done, 0);     chk("sh_done1", done1, 0);
            chk("sh_bit", bit_out, w[W-k]);
            chk("sh_bit1", bit_out1, w[W-k]);
            chk("sh_found", found, m[k-1]);
            chk("sh_found1", found1, m[k-1]);
            if (k == 1) o_gnt = gnt;
            o_found[k-1] = found;
            if (rnd) add_random();
            req = pend; data = pack();
        end
        tick();
        chk("rep_done", done, 1);        chk("rep_done1", done1, 1);
        chk("rep_busy", busy, 1);        chk("rep_gnt", gnt, 0);
        chk("rep_found", found, 0);      chk("rep_bit", bit_out, 0);
        chk("rep_id", done_id, win);     chk("rep_id1", done_id1, win);
        chk("rep_cnt", match_cnt, exp_cnt);
        chk("rep_cnt1", match_cnt1, exp1);
        o_id = int'(done_id); o_cnt = int'(match_cnt); o_cnt1 = int'(match_cnt1);
        last_id = win; last_cnt = exp_cnt; last_cnt1 = exp1;
        tick();
    endtask

    initial begin
        logic [N-1:0] g;
        logic [W-1:0] fm;
        int           id, c, c1;

        //            req      word          gnt      id cnt c1 fmask         fmask_ab      cnt_ab
        tbl[0] = '{4'b0001, 8'b1100_1100, 4'b0001, 0, 2, 1, 8'b1000_1000, 8'b0000_1000, 1};
        tbl[1] = '{4'b0001, 8'b0000_0110, 4'b0001, 0, 0, 0, 8'b0000_0000, 8'b0000_0000, 0};
        tbl[2] = '{4'b0001, 8'b0011_1111, 4'b0001, 0, 0, 0, 8'b0000_0000, 8'b0000_0000, 0};
        tbl[3] = '{4'b0001, 8'b1111_0000, 4'b0001, 0, 1, 1, 8'b0010_0000, 8'b0010_0000, 1};
        tbl[4] = '{4'b0100, 8'b0110_0110, 4'b0100, 2, 1, 1, 8'b0001_0000, 8'b0001_0000, 1};
        tbl[5] = '{4'b1000, 8'b1111_1100, 4'b1000, 3, 1, 1, 8'b1000_0000, 8'b1000_0000, 1};
        tbl[6] = '{4'b0010, 8'b1100_1100, 4'b0010, 1, 2, 1, 8'b1000_1000, 8'b0000_1000, 1};

        reset = 1'b1; req = '0; data = '0; pend = '0;
        for (int i = 0; i < N; i++) words[i] = '0;
        model_reset();
        do_reset();

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < N; i++) if (tbl[v].req[i]) words[i] = tbl[v].word;
            pend = tbl[v].req;
            serve(1'b1, 1'b0, g, id, c, c1, fm);
            chk("tbl_gnt", g, tbl[v].gnt);
            chk("tbl_id", id, tbl[v].id);
            chk("tbl_cnt1", c1, tbl[v].cnt1);
`ifdef SEQ_DET_EARLY_ABORT_EN
            chk("tbl_cnt", c, tbl[v].cnt_ab);
            chk("tbl_found", fm, tbl[v].fmask_ab);
`else
            chk("tbl_cnt", c, tbl[v].cnt);
            chk("tbl_found", fm, tbl[v].fmask);
`endif
        end

        // Contention: requesters 1 and 3 hold their requests throughout.
        do_reset();
        words[1] = 8'h3C; words[3] = 8'hC3;
        pend = 4'b1010;
        serve(1'b0, 1'b0, g, id, c, c1, fm);
        chk("rr_gnt_a", g, 4'b0010); chk("rr_id_a", id, 1);
        serve(1'b0, 1'b0, g, id, c, c1, fm);
        chk("rr_gnt_b", g, 4'b1000); chk("rr_id_b", id, 3);
        serve(1'b0, 1'b0, g, id, c, c1, fm);
        chk("rr_gnt_c", g, 4'b0010); chk("rr_id_c", id, 1);

        // Reset in the fourth SHIFT cycle aborts the word.
        do_reset();
        words[2] = 8'b1100_1100; pend = 4'b0100;
        req = pend; data = pack();
        tick();
        chk("mid_gnt", gnt, 4'b0100);
        tick(); tick(); tick();
        chk("mid_found4", found, 1);
        reset = 1'b1;
        words[0] = 8'hA5; pend = 4'b0001;
        req = pend; data = pack();
        tick();
        chk_zero("mid");
        reset = 1'b0;
        model_reset();
        serve(1'b1, 1'b0, g, id, c, c1, fm);
        chk("mid_regrant", g, 4'b0001);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            add_random();
            if ($urandom_range(0, 7) == 0) pend[$urandom_range(0, N - 1)] = 1'b0;
            serve(1'b1, 1'b1, g, id, c, c1, fm);
        end

        pend = '0; req = '0;
        tick();
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin scheduler that shares one serial pattern detector among `N_REQ` requesters. Each requester presents a parallel word; the arbiter grants one, serializes it MSB-first into the detector, counts pattern hits, and reports the result with the winning requester's ID. It sits between the parallel word sources and the Mealy-style detector core, and is the only block that drives the detector.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `WORD_W`, default 8: bits per word, at least 4.
- `CNT_W`, default 4: width of the match counter, which saturates.
- `PATTERN`, default 4'b1100: 4-bit sequence to detect; the first-received bit is the MSB.

Ports (`ID_W` = $clog2(N_REQ)):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request; held high until granted.
- `data`  in  N_REQ*WORD_W  word of requester i at bits [i*WORD_W +: WORD_W].
- `gnt`  out  N_REQ  one-hot, one-cycle pulse marking the word accepted.
- `busy`  out  1  high from the grant cycle through the report cycle.
- `bit_out`  out  1  serial bit currently driven into the detector.
- `found`  out  1  combinational detector hit in the current shift cycle.
- `done`  out  1  one-cycle result-valid pulse.
- `done_id`  out  ID_W  ID of the granted requester; valid from grant until the next grant.
- `match_cnt`  out  CNT_W  number of hits for the last word; held until the next grant.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- **IDLE to SHIFT:**
  - Taken when `req` is non-zero.
  - Winner is the first set bit at or after `rr_ptr`, searching cyclically.
  - On that edge, latch the winner's word into the shift register and set `done_id`.
  - Clear `match_cnt`, the detector window and the bit counter.
  - Set `rr_ptr` to winner+1, modulo `N_REQ`.
- **SHIFT:**
  - `bit_out` is the shift register's MSB.
  - `found` = ({window[2:0], bit_out} == PATTERN) and the bit index is at least 3. The window is cleared per word, so a hit never spans two words.
  - Each edge shifts the register left, shifts `bit_out` into the window, increments the bit counter, and increments `match_cnt` if `found` and the counter is not saturated at 2^CNT_W−1.
  - Overlapping hits are counted.
  - After `WORD_W` SHIFT cycles, go to REPORT.
- **REPORT:** `done` is 1 for one cycle, then the FSM goes to IDLE.
- A request arriving in SHIFT or REPORT waits; it is arbitrated in the next IDLE cycle.
- `req` changing during SHIFT has no effect. A requester deasserting before its grant simply loses eligibility.
- **Reset values:**
  - Outputs: `gnt`=0, `busy`=0, `bit_out`=0, `found`=0, `done`=0, `done_id`=0, `match_cnt`=0.
  - Internal: state=IDLE, `rr_ptr`=0.
- Reset asserted mid-word aborts it; no `done` is produced.

## Timing
- Cycle 0: IDLE with `req` non-zero.
- Cycle 1: `gnt` pulse, `busy`=1, first SHIFT cycle.
- Cycles 1..WORD_W: SHIFT.
- Cycle WORD_W+1: REPORT, with `done`=1.
- Cycle WORD_W+2: IDLE. Arbitration repeats, so the next grant is at cycle WORD_W+3.
- Throughput: one word per WORD_W+2 cycles.
- `found` is Mealy, valid in the same cycle as `bit_out`. `match_cnt` reflects that hit after the edge.

## Configuration
- `SEQ_DET_EARLY_ABORT_EN` defined:
  - A SHIFT cycle with `found`=1 is the last SHIFT cycle; REPORT follows on the next edge with `match_cnt`=1.
  - Remaining bits are discarded.
- Undefined: all `WORD_W` bits are always shifted, and every hit is counted.

## Structure
- Package `seq_det_pkg` holds:
  - the FSM state typedef: IDLE=2'b00, SHIFT=2'b01, REPORT=2'b10;
  - FOUND/NOTFOUND constants (1/0);
  - the default `PATTERN` constant.
- Sub-module `seq_window_det` contains the 4-bit window, its synchronous clear, the bit-index qualification and the `found` compare.
- The arbiter, serializer, counter and FSM stay in `seq_det_arbiter`.

## Test plan
- **Single word with two hits:** reset, then `req`=4'b0001, word0=8'b1100_1100.
  - `gnt`=0001 at cycle 1.
  - `found` in cycles 4 and 8.
  - `done` at cycle 9 with `done_id`=0, `match_cnt`=2.
- **Contention:** after reset, `req`=4'b1010 held.
  - Grant 0010 first, `done_id`=1.
  - Next grant 1000, `done_id`=3.
  - Then 0010 again: rotation is verified.
- **Saturation:** `CNT_W`=1, word 8'b1100_1100 gives `match_cnt`=1. Word 8'b1111_0000 gives `match_cnt`=1 with its hit in cycle 6.
- **No hit / window clear:** word 8'b0000_0110 followed by word 8'b0011_1111.
  - Both report `match_cnt`=0.
  - No hit across the word boundary.
- **Reset mid-word:** `reset`=1 in cycle 4 of SHIFT.
  - Next cycle: all outputs 0 and no `done`.
  - A pending `req`=0001 is granted one cycle after `reset` deasserts.
- **Early abort (`SEQ_DET_EARLY_ABORT_EN`):** word 8'b1100_1100.
  - `found` at cycle 4.
  - `done` at cycle 5 with `match_cnt`=1.
